// File: rtl/msu_audio_player.sv
// msu_audio_player: MSU-1 audio sample FIFO consumer.
// An exact fractional accumulator produces a SAMPLE_HZ strobe from clk. On
// each strobe one stereo word is popped from the show-ahead FIFO, the 8-bit
// MSU-1 volume is applied, and registered signed 16-bit L/R samples go out.
// Optional feature macro: MSU_AUDIO_VOLRAMP_EN (volume slews one step per
// sample instead of jumping, to avoid zipper noise).

// Per-channel volume scaler: 255 is an exact pass-through, anything else is
// (raw * vol) >>> 8, which can never exceed |raw|, so no saturation is needed.
module msu_audio_lane (
  input  logic [15:0] raw,
  input  logic [7:0]  vol,
  output logic [15:0] y
);
  logic signed [24:0] prod;
  logic               prod_unused;

  assign prod        = $signed(raw) * $signed({1'b0, vol});
  assign prod_unused = ^{prod[24], prod[7:0]};
  assign y           = (vol == 8'hFF) ? raw : prod[23:8];
endmodule

module msu_audio_player #(
  parameter int CLK_HZ    = 21477270,
  parameter int SAMPLE_HZ = 44100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        play,
  input  logic [7:0]  volume,
  input  logic [31:0] fifo_q,
  input  logic        fifo_empty,
  output logic        fifo_rdreq,
  output logic [15:0] audio_l,
  output logic [15:0] audio_r,
  output logic        sample_tick,
  output logic        underrun
);
  localparam int STAGES    = 2;
  localparam int NUM_LANES = 2;  // lane 0 = left, lane 1 = right

  logic [25:0]                 acc, acc_sum;
  logic                        tick;
  logic [STAGES:0]             vld_pipe;
  logic [STAGES:1]             vld_q;
  logic [NUM_LANES-1:0][15:0]  raw, scaled, aud;
  logic [7:0]                  vol_eff, vol_nxt;

  // Accumulator wraps by CLK_HZ whenever it crosses it: exact long-term rate.
  assign acc_sum  = acc + 26'(SAMPLE_HZ);
  assign tick     = (acc_sum >= 26'(CLK_HZ));
  assign vld_pipe = {vld_q, tick};

  // Rate generator runs regardless of play.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc <= '0;
    else       acc <= tick ? acc_sum - 26'(CLK_HZ) : acc_sum;
  end

  // Strobe shift register: T -> T+1 (scale) -> T+2 (sample_tick).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_q <= '0;
    else       vld_q <= vld_pipe[STAGES-1:0];
  end

  // Fetch: latch the show-ahead word (or silence) and decide pop/underrun on T.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw        <= '0;
      fifo_rdreq <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      fifo_rdreq <= tick & play & ~fifo_empty;
      underrun   <= tick & play & fifo_empty;
      if (tick) raw <= (play && !fifo_empty) ? fifo_q : '0;
    end
  end

  // Effective volume for the sample being scaled this cycle.
  always_comb begin
    vol_nxt = vol_eff;
`ifdef MSU_AUDIO_VOLRAMP_EN
    if (vol_eff < volume)      vol_nxt = vol_eff + 8'd1;
    else if (vol_eff > volume) vol_nxt = vol_eff - 8'd1;
`else
    vol_nxt = volume;
`endif
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    msu_audio_lane u_lane (
      .raw (raw[i]),
      .vol (vol_nxt),
      .y   (scaled[i])
    );
  end

  // Scale stage: volume step and output register both happen at T+1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vol_eff <= '0;
      aud     <= '0;
    end else if (vld_pipe[1]) begin
      vol_eff <= vol_nxt;
      aud     <= scaled;
    end
  end

  assign audio_l     = aud[0];
  assign audio_r     = aud[1];
  assign sample_tick = vld_pipe[STAGES];
endmodule

// File: tb/tb_msu_audio_player.sv
// tb_msu_audio_player: directed bench with a FIFO model and expected-sample
// scoreboard. Runs with CLK_HZ=10, SAMPLE_HZ=3 so ticks come every 3-4 cycles.
module tb_msu_audio_player;
  localparam int CLK_HZ    = 10;
  localparam int SAMPLE_HZ = 3;

  logic        clk = 1'b0, reset = 1'b1, play = 1'b0, fifo_empty = 1'b1;
  logic [7:0]  volume = 8'd0;
  logic [31:0] fifo_q = 32'd0;
  logic        fifo_rdreq, sample_tick, underrun;
  logic [15:0] audio_l, audio_r;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          pops;
    int          unds;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] fq[$];
  int checks = 0, errors = 0;
  int cyc = 0, st_cnt = 0, rd_cnt = 0, un_cnt = 0;
  int first_st = -1, last_st = -1, bad_sp = 0, bad_pop = 0;

  msu_audio_player #(.CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ)) dut (
    .clk(clk), .reset(reset), .play(play), .volume(volume),
    .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq),
    .audio_l(audio_l), .audio_r(audio_r), .sample_tick(sample_tick),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic void refresh();
    fifo_empty = (fq.size() == 0);
    fifo_q     = fifo_empty ? 32'd0 : fq[0];
  endfunction

  // Monitor: event counters, tick spacing, and FIFO pops (sampled mid-cycle).
  always @(negedge clk) begin
    if (sample_tick) begin
      st_cnt++;
      if (!reset) begin
        if (first_st < 0) first_st = cyc;
        if (last_st >= 0 && (cyc - last_st) != 3 && (cyc - last_st) != 4) bad_sp++;
        last_st = cyc;
      end
    end
    if (fifo_rdreq) begin
      rd_cnt++;
      if (fq.size() == 0) bad_pop++;
      else void'(fq.pop_front());
      refresh();
    end
    if (underrun) un_cnt++;
    if (reset) begin
      cyc = 0; first_st = -1; last_st = -1;
    end else cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_st(input string tag);
    int n;
    bit ok;
    n  = st_cnt;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk); #1;
      if (st_cnt != n) ok = 1'b1;
    end
    chk({tag, "_arrive"}, 32'(ok), 32'd1);
  endtask

  // Sync to a sample, apply inputs before the next tick, then score that tick.
  task automatic step(input string tag, input logic p, input logic [7:0] v,
                      input bit push, input logic [31:0] word,
                      input logic [15:0] el, input logic [15:0] er,
                      input int epop, input int eund);
    int   r0, u0;
    exp_t e;
    wait_st({tag, "_sync"});
    play   = p;
    volume = v;
    if (push) begin
      fq.push_back(word);
      refresh();
    end
    r0 = rd_cnt;
    u0 = un_cnt;
    sb.push_back('{el, er, epop, eund});
    wait_st(tag);
    e = sb.pop_front();
    chk({tag, "_l"}, 32'(audio_l), 32'(e.l));
    chk({tag, "_r"}, 32'(audio_r), 32'(e.r));
    chk({tag, "_pops"}, 32'(rd_cnt - r0), 32'(e.pops));
    chk({tag, "_underrun"}, 32'(un_cnt - u0), 32'(e.unds));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    exp_t e;
    logic [31:0] m;
    repeat (3) @(negedge clk);
    chk("rst_l", 32'(audio_l), 32'd0);
    chk("rst_r", 32'(audio_r), 32'd0);
    chk("rst_rdreq", 32'(fifo_rdreq), 32'd0);
    chk("rst_tick", 32'(sample_tick), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Rate: cycles 0..1001 carry the sample_ticks of ticks in cycles 0..999.
    for (int i = 0; i < 1100 && cyc < 1002; i++) begin
      @(negedge clk); #1;
    end
    chk("rate_count", 32'(st_cnt), 32'd300);
    chk("rate_first", 32'(first_st), 32'd5);
    chk("rate_spacing", 32'(bad_sp), 32'd0);
    chk("rate_nopop", 32'(rd_cnt), 32'd0);
    chk("rate_nounder", 32'(un_cnt), 32'd0);

`ifdef MSU_AUDIO_VOLRAMP_EN
    wait_st("ramp_sync");
    play   = 1'b1;
    volume = 8'd255;
    for (int i = 0; i < 300; i++) fq.push_back(32'h7FFF_7FFF);
    refresh();
    for (int k = 1; k <= 255; k++) begin
      m = (k == 255) ? 32'h7FFF : ((32'd32767 * 32'(k)) >> 8);
      sb.push_back('{m[15:0], m[15:0], 1, 0});
      wait_st("ramp");
      e = sb.pop_front();
      chk("ramp_l", 32'(audio_l), 32'(e.l));
      chk("ramp_r", 32'(audio_r), 32'(e.r));
    end
    fq.delete();
    refresh();
`else
    step("play",   1'b1, 8'd255, 1'b1, 32'h8000_7FFF, 16'h7FFF, 16'h8000, 1, 0);
    step("half",   1'b1, 8'd128, 1'b1, 32'hC000_4000, 16'h2000, 16'hE000, 1, 0);
    step("under",  1'b1, 8'd255, 1'b0, 32'h0,         16'h0000, 16'h0000, 0, 1);
    step("resume", 1'b1, 8'd255, 1'b1, 32'h0001_FFFF, 16'hFFFF, 16'h0001, 1, 0);
    step("mute",   1'b1, 8'd0,   1'b1, 32'h1234_5678, 16'h0000, 16'h0000, 1, 0);
    step("neg",    1'b1, 8'd64,  1'b1, 32'h8000_FFFF, 16'hFFFF, 16'hE000, 1, 0);
    step("v254",   1'b1, 8'd254, 1'b1, 32'h7FFF_7FFF, 16'h7EFF, 16'h7EFF, 1, 0);
    step("stop",   1'b0, 8'd255, 1'b1, 32'h1111_2222, 16'h0000, 16'h0000, 0, 0);
    step("drain",  1'b1, 8'd255, 1'b0, 32'h0,         16'h2222, 16'h1111, 1, 0);
`endif

    // Reset while a sample is between fetch and output.
    wait_st("rst_sync");
    fq.delete();
    play   = 1'b1;
    volume = 8'd255;
    fq.push_back(32'h5555_AAAA);
    refresh();
    n = rd_cnt;
    for (int i = 0; i < 10 && rd_cnt == n; i++) begin
      @(negedge clk); #1;
    end
    chk("mid_pop_seen", 32'(rd_cnt - n), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_l", 32'(audio_l), 32'd0);
    chk("mid_r", 32'(audio_r), 32'd0);
    chk("mid_rdreq", 32'(fifo_rdreq), 32'd0);
    chk("mid_underrun", 32'(underrun), 32'd0);
    n = st_cnt;
    repeat (3) begin
      @(negedge clk); #1;
    end
    chk("mid_notick", 32'(st_cnt - n), 32'd0);
    play = 1'b0;
    fq.delete();
    refresh();
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 20 && first_st < 0; i++) begin
      @(negedge clk); #1;
    end
    chk("rel_first", 32'(first_st), 32'd5);
    chk("rel_l", 32'(audio_l), 32'd0);
    chk("fin_spacing", 32'(bad_sp), 32'd0);
    chk("fin_badpop", 32'(bad_pop), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/msu_audio_player.md
# msu_audio_player

Downstream consumer of the MSU-1 audio sample FIFO. Runs in the FIFO read-clock domain and generates a 44.1 kHz sample strobe from the system clock using an exact fractional accumulator. On each strobe it pops one 32-bit stereo word from the show-ahead FIFO and applies the MSU-1 8-bit volume. It delivers registered signed 16-bit left/right samples to the SNES audio mixer, and reports underruns.

## Interface
Parameters:
- CLK_HZ, 21477270, clock frequency in Hz; 2..2^25-1.
- SAMPLE_HZ, 44100, output sample rate in Hz; must be less than CLK_HZ.

Ports:
- clk  in  1  system clock; also the FIFO read clock.
- reset  in  1  asynchronous, active-high reset.
- play  in  1  playback enable; level-sensitive.
- volume  in  8  MSU-1 volume register; 0 = mute, 255 = unity.
- fifo_q  in  32  FIFO show-ahead data; [15:0] left, [31:16] right, signed two's complement.
- fifo_empty  in  1  FIFO read-side empty flag.
- fifo_rdreq  out  1  FIFO pop strobe; one cycle wide.
- audio_l  out  16  signed left sample.
- audio_r  out  16  signed right sample.
- sample_tick  out  1  one-cycle pulse; audio_l and audio_r were updated on this cycle's edge.
- underrun  out  1  one-cycle pulse when a sample was due but the FIFO was empty.

## Operation
- Rate generator (26-bit accumulator `acc`):
  - Every cycle, if acc + SAMPLE_HZ >= CLK_HZ: acc <= acc + SAMPLE_HZ - CLK_HZ and internal `tick` = 1.
  - Otherwise: acc <= acc + SAMPLE_HZ and tick = 0.
  - Exactly SAMPLE_HZ ticks occur per CLK_HZ cycles. Tick spacing is floor or ceil of CLK_HZ/SAMPLE_HZ; there is no drift.
  - The generator runs whether or not play is asserted.
- Fetch stage (cycle T = tick cycle), decided on tick alone:
  - play=1, fifo_empty=0: raw_l/raw_r <= fifo_q; fifo_rdreq=1 in cycle T+1.
  - play=1, fifo_empty=1: raw_l/raw_r <= 0; underrun=1 in cycle T+1; no pop.
  - play=0: raw_l/raw_r <= 0; no pop; no underrun.
- Volume:
  - `vol_eff` is updated at T+1 (see Configuration).
- Scale stage (T+1 -> T+2):
  - If vol_eff = 255: output = raw (exact pass-through).
  - Otherwise: output = (raw × {1'b0,vol_eff}) >>> 8, using a 25-bit signed product and arithmetic shift, i.e. product[23:8].
  - No saturation is needed, because |result| <= |raw|.
- Output: audio_l/audio_r are registered at the edge ending T+1, and sample_tick=1 during T+2.
- Play transitions take effect at the next tick; there is no flush of in-flight stages.

## Timing
- Reset values: acc=0, raw_l=raw_r=0, audio_l=audio_r=0, vol_eff=0, fifo_rdreq=0, sample_tick=0, underrun=0.
- Latency: tick at T -> fifo_rdreq and underrun at T+1 -> sample_tick and new audio at T+2.
- fifo_rdreq is never asserted while fifo_empty was 1 in the deciding cycle T. At most one pop occurs per tick.
- The data consumed is the fifo_q value in cycle T. The pop at T+1 retires that word.
- fifo_empty changing during T+1 or T+2 has no effect.
- Reset asserted mid-pipeline clears all stages immediately. After release, the first tick occurs at cycle ceil(CLK_HZ/SAMPLE_HZ)-1.
- Outputs hold their value between sample_tick pulses.

## Configuration
- MSU_AUDIO_VOLRAMP_EN
  - Defined: at T+1, vol_eff moves one step toward `volume` (+1 if lower, -1 if higher, unchanged if equal). A 0->255 change completes after 255 ticks, which avoids zipper clicks.
  - Undefined: at T+1, vol_eff <= volume. The step applies to the same sample.

## Test plan
- Rate: CLK_HZ=10, SAMPLE_HZ=3, 1000 cycles after reset -> exactly 300 sample_tick pulses; spacings only 3 or 4.
- Playback: FIFO holds 0x8000_7FFF, volume=255, play=1 -> audio_l=0x7FFF, audio_r=0x8000 on the following sample_tick; exactly one fifo_rdreq.
- Scaling (ramp undefined): volume=128, sample L=0x4000 R=0xC000 -> audio_l=0x2000, audio_r=0xE000. With volume=0 -> both 0.
- Underrun: play=1, fifo_empty=1 at tick -> underrun pulse at T+1, audio 0 at T+2, fifo_rdreq stays 0. When data returns, the next tick outputs it.
- Stop/reset: play=0 -> zero output, no pops, ticks continue. Assert reset between T and T+2 -> all outputs 0 and no sample_tick.
- Ramp (macro defined): volume 0->255 with constant full-scale input -> vol_eff increases by 1 per tick; pass-through is reached on the 255th tick.
